// File: rtl/seven_seg_scan.sv
// seven_seg_scan: N-digit multiplexed 7-segment driver with an iterative
// double-dabble binary-to-BCD converter, leading-zero blanking, overflow
// dashes and selectable output polarity.
module seven_seg_scan #(
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_lz,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BIT_W = $clog2(BIN_W + 1);
  localparam bit INVERT = (ACTIVE_LOW != 0);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  function automatic logic [6:0] encodeDigit(input logic [3:0] d);
    case (d)
      4'd0:    encodeDigit = 7'b1111110;
      4'd1:    encodeDigit = 7'b0110000;
      4'd2:    encodeDigit = 7'b1101101;
      4'd3:    encodeDigit = 7'b1111001;
      4'd4:    encodeDigit = 7'b0110011;
      4'd5:    encodeDigit = 7'b1011011;
      4'd6:    encodeDigit = 7'b0011111;
      4'd7:    encodeDigit = 7'b1110000;
      4'd8:    encodeDigit = 7'b1111111;
      4'd9:    encodeDigit = 7'b1111011;
      default: encodeDigit = 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t             state;
  state_t             stateNext;
  logic [BIN_W-1:0]   binReg;
  logic [BCD_W-1:0]   bcdReg;
  logic [BCD_W-1:0]   bcdAdj;
  logic [BCD_W+BIN_W-1:0] shiftVal;
  logic [BIT_W-1:0]   bitCnt;
  logic               ovfQ;
  logic [BCD_W-1:0]   disp;
  logic [CNT_W-1:0]   scanCnt;
  logic [IDX_W-1:0]   idx;
  logic [DIGITS-1:0]  upperZero;
  logic [3:0]         curDigit;
  logic [6:0]         segNext;
  logic [DIGITS-1:0]  anNext;

  assign busy = (state != IDLE);

  // Conversion FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state: IDLE waits for load, CONVERT runs BIN_W shifts, COMMIT publishes
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load) stateNext = CONVERT;
      CONVERT: if (bitCnt == BIT_W'(1)) stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift
  always_comb begin
    bcdAdj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdReg[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
      else                          bcdAdj[4*i +: 4] = bcdReg[4*i +: 4];
    end
  end

  assign shiftVal = {bcdAdj, binReg} << 1;

  // Conversion datapath and the display register that only changes on COMMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      binReg   <= '0;
      bcdReg   <= '0;
      bitCnt   <= '0;
      ovfQ     <= 1'b0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            binReg <= value;
            bcdReg <= '0;
            bitCnt <= BIT_W'(BIN_W);
            ovfQ   <= (64'(value) >= LIMIT);
          end
        end
        CONVERT: begin
          bcdReg <= shiftVal[BCD_W+BIN_W-1:BIN_W];
          binReg <= shiftVal[BIN_W-1:0];
          bitCnt <= bitCnt - BIT_W'(1);
        end
        COMMIT: begin
          disp     <= bcdReg;
          overflow <= ovfQ;
        end
        default: ;
      endcase
    end
  end

  // Scan timing: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      scanCnt <= '0;
      idx     <= '0;
    end else if (scanCnt == CNT_W'(SCAN_DIV - 1)) begin
      scanCnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scanCnt <= scanCnt + CNT_W'(1);
    end
  end

  // upperZero[k] is set when digit k and every digit above it are zero
  always_comb begin
    upperZero = '0;
    for (int k = 0; k < DIGITS; k++) begin
      upperZero[k] = ((disp >> (4*k)) == '0);
    end
  end

  // Segment/anode pattern for the currently selected digit
  always_comb begin
    curDigit = disp[{idx, 2'b00} +: 4];
    anNext   = '0;
    anNext[idx] = 1'b1;
    if (overflow)                                   segNext = 7'b0000001;
    else if (blank_lz && idx != '0 && upperZero[idx]) segNext = 7'b0000000;
    else                                            segNext = encodeDigit(curDigit);
  end

  // Registered outputs with polarity applied last
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= {7{INVERT}};
      an  <= {DIGITS{INVERT}};
    end else begin
      seg <= segNext ^ {7{INVERT}};
      an  <= anNext ^ {DIGITS{INVERT}};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan: an active-high and an active-low instance
// share stimulus; outputs are compared to a decimal-arithmetic display model.
module tb_seven_seg_scan;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic             clock;
  logic             reset;
  logic [BIN_W-1:0] value;
  logic             load;
  logic             blankLz;
  logic             busy, busyInv;
  logic             overflow, overflowInv;
  logic [6:0]       seg, segInv;
  logic [3:0]       an, anInv;

  int total = 0;
  int bad   = 0;
  int cyc;
  int modelVal;

  seven_seg_scan #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) dut (
    .clk(clock), .reset(reset), .value(value), .load(load), .blank_lz(blankLz),
    .busy(busy), .overflow(overflow), .seg(seg), .an(an)
  );

  seven_seg_scan #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dutInv (
    .clk(clock), .reset(reset), .value(value), .load(load), .blank_lz(blankLz),
    .busy(busyInv), .overflow(overflowInv), .seg(segInv), .an(anInv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges elapsed since reset was released
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b0011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {seg, an} when digit position pos is lit, from plain decimal arithmetic
  function automatic logic [10:0] expectedOut(input int pos);
    logic [6:0] s;
    logic [3:0] a;
    a = 4'(1 << pos);
    if (modelVal >= pow10(DIGITS))                      s = 7'b0000001;
    else if (blankLz && pos != 0 && modelVal < pow10(pos)) s = 7'b0000000;
    else                                                 s = segOf((modelVal / pow10(pos)) % 10);
    return {s, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare both instances against the model for a number of cycles
  task automatic checkScan(input string tag, input int cycles);
    int pos;
    logic [10:0] e;
    logic [10:0] eInv;
    repeat (cycles) begin
      @(negedge clock);
      pos  = ((cyc - 1) / SCAN_DIV) % DIGITS;
      e    = expectedOut(pos);
      eInv = ~e;
      checkOutput(tag, 32'({seg, an}), 32'(e));
      checkOutput({tag, "_inv"}, 32'({segInv, anInv}), 32'(eInv));
    end
  endtask

  task automatic resetDut(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    load  = 1'b0;
    repeat (cycles) @(negedge clock);
    reset    = 1'b0;
    modelVal = 0;
  endtask

  // Wait for busy to drop, returning how many sampled cycles it was high
  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  // Load a value, check busy length and overflow flag
  task automatic applyStimulus(input int v);
    int n;
    @(negedge clock);
    value = BIN_W'(v);
    load  = 1'b1;
    @(negedge clock);
    load     = 1'b0;
    modelVal = v;
    waitIdle(n);
    checkOutput("busy_len", 32'(n), 32'(BIN_W + 1));
    checkOutput("overflow", 32'(overflow), 32'(modelVal >= pow10(DIGITS)));
  endtask

  initial begin
    int n;
    int v;
    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    blankLz  = 1'b0;
    modelVal = 0;

    repeat (3) @(negedge clock);
    checkOutput("rst_seg", 32'(seg), 32'h00);
    checkOutput("rst_an", 32'(an), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    checkOutput("rst_seg_inv", 32'(segInv), 32'h7F);
    checkOutput("rst_an_inv", 32'(anInv), 32'hF);
    reset = 1'b0;
    checkScan("post_rst", DIGITS * SCAN_DIV);

    applyStimulus(1234);
    checkScan("v1234", 2 * DIGITS * SCAN_DIV);

    blankLz = 1'b1;
    applyStimulus(7);
    checkScan("blank7", DIGITS * SCAN_DIV);
    applyStimulus(0);
    checkScan("blank0", DIGITS * SCAN_DIV);
    blankLz = 1'b0;

    applyStimulus(10000);
    checkScan("ovf10000", DIGITS * SCAN_DIV);
    blankLz = 1'b1;
    applyStimulus(16383);
    checkScan("ovf16383", DIGITS * SCAN_DIV);
    blankLz = 1'b0;
    applyStimulus(9999);
    checkScan("v9999", DIGITS * SCAN_DIV);

    // A load while converting must be dropped
    @(negedge clock);
    value = BIN_W'(1234);
    load  = 1'b1;
    @(negedge clock);
    load     = 1'b0;
    modelVal = 1234;
    repeat (3) @(negedge clock);
    value = BIN_W'(5678);
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
    value = '0;
    waitIdle(n);
    checkScan("ignored_load", DIGITS * SCAN_DIV);

    // Reset in the middle of a conversion
    @(negedge clock);
    value = BIN_W'(4321);
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("mid_busy", 32'(busy), 32'h1);
    resetDut(2);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkScan("abort_zero", DIGITS * SCAN_DIV);

    // Randomized values, biased toward small numbers so blanking gets exercised
    for (int i = 0; i < 25; i++) begin
      blankLz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 16383));
      else                           v = int'($urandom_range(0, 150));
      applyStimulus(v);
      checkScan("random", DIGITS * SCAN_DIV);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
